mem_bus_ctrl: RTL

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl_if.sv | 39 +++
 rtl/mem_bus_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl_if.sv
// Request/response and MMIO bus bundle for mem_bus_ctrl.
// slave = controller view, master = requester/MMIO environment view.
interface mem_bus_ctrl_if;
   logic        ReqValid;
   logic        ReqReady;
   logic        ReqWrite;
   logic [1:0]  ReqSize;
   logic        ReqUnsigned;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        RespValid;
   logic [31:0] ReadData;
   logic        Misaligned;
   logic        BusError;
   logic        MmioReq;
   logic        MmioWrite;
   logic [31:0] MmioAddr;
   logic [31:0] MmioWdata;
   logic [3:0]  MmioBe;
   logic [31:0] MmioRdata;
   logic        MmioAck;

   // Handshake: a request is taken on a rising edge where ReqValid & ReqReady;
   // RespValid is a one-cycle strobe and ReadData/Misaligned/BusError hold until
   // the next strobe; MmioReq and all Mmio* outputs stay stable until MmioAck.
   modport slave (
      input  ReqValid, ReqWrite, ReqSize, ReqUnsigned, Address, WriteData,
      input  MmioRdata, MmioAck,
      output ReqReady, RespValid, ReadData, Misaligned, BusError,
      output MmioReq, MmioWrite, MmioAddr, MmioWdata, MmioBe
   );

   modport master (
      output ReqValid, ReqWrite, ReqSize, ReqUnsigned, Address, WriteData,
      output MmioRdata, MmioAck,
      input  ReqReady, RespValid, ReadData, Misaligned, BusError,
      input  MmioReq, MmioWrite, MmioAddr, MmioWdata, MmioBe
   );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Load/store controller routing requests to an internal data RAM or an MMIO port.
// Define MEM_BUS_TIMEOUT_EN to add the MMIO wait timeout (bus error after TIMEOUT_CYCLES).
module mem_bus_ctrl #(
   parameter int          RAM_WORDS      = 16384,
   parameter logic [15:0] MMIO_PAGE      = 16'hFFFF,
   parameter int          TIMEOUT_CYCLES = 15
) (
   input  logic         clk,
   input  logic         reset,
   mem_bus_ctrl_if.slave bus
);

   localparam int AW = $clog2(RAM_WORDS);

   typedef enum logic [1:0] {IDLE, RAM, MMIO_WAIT, RESP} state_t;
   state_t state;

   logic [31:0]   ram [RAM_WORDS];

   logic          r_write;
   logic [1:0]    r_size;
   logic          r_unsigned;
   logic [AW+1:0] r_addr;
   logic [31:0]   r_wdata;
   logic [3:0]    r_be;

   logic [AW-1:0] ram_idx;
   assign ram_idx = r_addr[AW+1:2];

   logic        misaligned_c;
   logic        ram_hit_c;
   logic        mmio_hit_c;
   logic [3:0]  be_c;
   logic [31:0] wrep_c;

   always_comb begin
      misaligned_c = (bus.ReqSize == 2'b11) ||
                     (bus.ReqSize == 2'b01 && bus.Address[0]) ||
                     (bus.ReqSize == 2'b10 && bus.Address[1:0] != 2'b00);
      ram_hit_c    = (bus.Address[31:AW+2] == '0);
      mmio_hit_c   = (bus.Address[31:16] == MMIO_PAGE);
      case (bus.ReqSize)
         2'b00: begin
            be_c   = 4'b0001 << bus.Address[1:0];
            wrep_c = {4{bus.WriteData[7:0]}};
         end
         2'b01: begin
            be_c   = bus.Address[1] ? 4'b1100 : 4'b0011;
            wrep_c = {2{bus.WriteData[15:0]}};
         end
         default: begin
            be_c   = 4'b1111;
            wrep_c = bus.WriteData;
         end
      endcase
   end

   // Pick the addressed byte/half out of a word and extend it to 32 bits.
   function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] a, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{a, 3'b000} +: 8];
      h = a[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   extract = uns ? {24'b0, b} : {{24{b[7]}}, b};
         2'b01:   extract = uns ? {16'b0, h} : {{16{h[15]}}, h};
         default: extract = word;
      endcase
   endfunction

`ifdef MEM_BUS_TIMEOUT_EN
   localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);
   logic [7:0] wait_cnt;
   logic [7:0] wait_cnt_next;
   assign wait_cnt_next = wait_cnt + 8'd1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         bus.ReqReady   <= 1'b1;
         bus.RespValid  <= 1'b0;
         bus.ReadData   <= '0;
         bus.Misaligned <= 1'b0;
         bus.BusError   <= 1'b0;
         bus.MmioReq    <= 1'b0;
         bus.MmioWrite  <= 1'b0;
         bus.MmioAddr   <= '0;
         bus.MmioWdata  <= '0;
         bus.MmioBe     <= '0;
         r_write        <= 1'b0;
         r_size         <= '0;
         r_unsigned     <= 1'b0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_be           <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
         wait_cnt       <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.ReqValid) begin
                  bus.ReqReady <= 1'b0;
                  r_write      <= bus.ReqWrite;
                  r_size       <= bus.ReqSize;
                  r_unsigned   <= bus.ReqUnsigned;
                  r_addr       <= bus.Address[AW+1:0];
                  r_wdata      <= wrep_c;
                  r_be         <= be_c;
                  // Alignment faults win over decode: nothing is touched.
                  if (misaligned_c) begin
                     state          <= RESP;
                     bus.RespValid  <= 1'b1;
                     bus.ReadData   <= '0;
                     bus.Misaligned <= 1'b1;
                     bus.BusError   <= 1'b0;
                  end else if (ram_hit_c) begin
                     state <= RAM;
                  end else if (mmio_hit_c) begin
                     state         <= MMIO_WAIT;
                     bus.MmioReq   <= 1'b1;
                     bus.MmioWrite <= bus.ReqWrite;
                     bus.MmioAddr  <= bus.Address;
                     bus.MmioWdata <= wrep_c;
                     bus.MmioBe    <= be_c;
`ifdef MEM_BUS_TIMEOUT_EN
                     wait_cnt      <= '0;
`endif
                  end else begin
                     state          <= RESP;
                     bus.RespValid  <= 1'b1;
                     bus.ReadData   <= '0;
                     bus.Misaligned <= 1'b0;
                     bus.BusError   <= 1'b1;
                  end
               end
            end
            RAM: begin
               state          <= RESP;
               bus.RespValid  <= 1'b1;
               bus.Misaligned <= 1'b0;
               bus.BusError   <= 1'b0;
               bus.ReadData   <= r_write ? 32'b0 :
                                 extract(ram[ram_idx], r_size, r_addr[1:0], r_unsigned);
            end
            MMIO_WAIT: begin
               if (bus.MmioAck) begin
                  state          <= RESP;
                  bus.RespValid  <= 1'b1;
                  bus.MmioReq    <= 1'b0;
                  bus.Misaligned <= 1'b0;
                  bus.BusError   <= 1'b0;
                  bus.ReadData   <= r_write ? 32'b0 :
                                    extract(bus.MmioRdata, r_size, r_addr[1:0], r_unsigned);
               end
`ifdef MEM_BUS_TIMEOUT_EN
               else if (wait_cnt_next == TMO) begin
                  state          <= RESP;
                  bus.RespValid  <= 1'b1;
                  bus.MmioReq    <= 1'b0;
                  bus.Misaligned <= 1'b0;
                  bus.BusError   <= 1'b1;
                  bus.ReadData   <= '0;
               end else begin
                  wait_cnt <= wait_cnt_next;
               end
`endif
            end
            RESP: begin
               state         <= IDLE;
               bus.RespValid <= 1'b0;
               bus.ReqReady  <= 1'b1;
            end
            default: begin
               state        <= IDLE;
               bus.ReqReady <= 1'b1;
            end
         endcase
      end
   end

   // RAM has no reset; a reset during the RAM cycle suppresses the store.
   always_ff @(posedge clk) begin
      if (!reset && state == RAM && r_write) begin
         for (int i = 0; i < 4; i++) begin
            if (r_be[i]) ram[ram_idx][i*8 +: 8] <= r_wdata[i*8 +: 8];
         end
      end
   end

endmodule
